// File: rtl/convolution_z_readout_pkg.sv
// Shared types, default geometry and result-length helper for the Z readout stage.
package convolution_z_readout_pkg;

    localparam int unsigned DATAWIDTH_Z_DEF      = 16;
    localparam int unsigned MEM_ADDR_XY_SIZE_DEF = 5;
    localparam int unsigned SIZE_X_DEF           = 5;
    localparam int unsigned SIZE_Y_DEF           = 5;
    localparam int unsigned Z_DEPTH              = 2 ** (MEM_ADDR_XY_SIZE_DEF + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2,
        DONE    = 2'd3
    } z_rd_state_t;

    // Number of Z results: sizeX+sizeY-1 kept to sum_w bits, 0 if either size is 0,
    // clipped to the buffer depth.
    function automatic int unsigned conv_len(input int unsigned size_x,
                                             input int unsigned size_y,
                                             input int unsigned sum_w,
                                             input int unsigned depth);
        int unsigned sum;
        if (size_x == 0 || size_y == 0) begin
            return 0;
        end
        sum = (size_x + size_y - 1) & ((32'd1 << sum_w) - 32'd1);
        return (sum > depth) ? depth : sum;
    endfunction

endpackage

// File: rtl/convolution_z_readout_buffer.sv
// Z result buffer: register array with a written-bitmap; unwritten entries read as 0.
module convolution_z_readout_buffer
    import convolution_z_readout_pkg::*;
#(
    parameter int unsigned ADDR_W = MEM_ADDR_XY_SIZE_DEF + 1,
    parameter int unsigned DATA_W = DATAWIDTH_Z_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data_c
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  written;

    // Bitmap tracks which entries hold data from the current run.
    always_ff @(posedge clk) begin
        if (rst) begin
            written <= '0;
        end else if (clear) begin
            written <= '0;
        end else if (wr_en) begin
            written[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data_c = written[rd_addr] ? mem[rd_addr] : '0;

endmodule

// File: rtl/convolution_z_readout.sv
// Captures the convolution core's Z write stream and drains it in address order
// over a valid/ready stream once the core signals done.
module convolution_z_readout
    import convolution_z_readout_pkg::*;
#(
    parameter int unsigned DATAWIDTH_Z      = DATAWIDTH_Z_DEF,
    parameter int unsigned MEM_ADDR_XY_SIZE = MEM_ADDR_XY_SIZE_DEF,
    parameter int unsigned SIZE_X           = SIZE_X_DEF,
    parameter int unsigned SIZE_Y           = SIZE_Y_DEF
) (
    input  logic                        clk,
    input  logic                        rstn,
    input  logic                        conv_start,
    input  logic [SIZE_X-1:0]           sizeX,
    input  logic [SIZE_Y-1:0]           sizeY,
    input  logic                        conv_writeZ,
    input  logic [MEM_ADDR_XY_SIZE:0]   conv_memZ_addr,
    input  logic [DATAWIDTH_Z-1:0]      conv_dataZ,
    input  logic                        conv_done,
    output logic [DATAWIDTH_Z-1:0]      out_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done,
    output logic                        addr_err
);

    localparam int unsigned ADDR_W = MEM_ADDR_XY_SIZE + 1;
    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned LEN_W  = ADDR_W + 1;
    localparam logic [LEN_W-1:0]  LEN_ONE = LEN_W'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

    z_rd_state_t                state_q, state_d;
    logic [LEN_W-1:0]           len_q, len_d;
    logic [ADDR_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [DATAWIDTH_Z-1:0]     out_data_d;
    logic                       out_valid_d, out_last_d, busy_d, done_d, addr_err_d;

    logic [LEN_W-1:0]           new_len_c;
    logic                       addr_ok_c;
    logic                       buf_clear_c, buf_we_c;
    logic [ADDR_W-1:0]          rd_idx_c;
    logic [DATAWIDTH_Z-1:0]     rd_data_c;

    assign new_len_c = LEN_W'(conv_len(32'(sizeX), 32'(sizeY), SIZE_X + 1, DEPTH));
    assign addr_ok_c = LEN_W'(conv_memZ_addr) < len_q;

    convolution_z_readout_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATAWIDTH_Z)
    ) u_buffer (
        .clk       (clk),
        .rst       (rstn),
        .clear     (buf_clear_c),
        .wr_en     (buf_we_c),
        .wr_addr   (conv_memZ_addr),
        .wr_data   (conv_dataZ),
        .rd_addr   (rd_idx_c),
        .rd_data_c (rd_data_c)
    );

    // Read address: advance one entry ahead on an accepted non-final sample.
    always_comb begin
        rd_idx_c = rd_ptr_q;
        if (state_q == DRAIN && out_valid_q_c() && out_ready && !out_last) begin
            rd_idx_c = rd_ptr_q + PTR_ONE;
        end
    end

    function automatic logic out_valid_q_c();
        return out_valid;
    endfunction

    always_ff @(posedge clk) begin
        if (rstn) begin
            state_q   <= IDLE;
            len_q     <= '0;
            rd_ptr_q  <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            addr_err  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_ptr_q  <= rd_ptr_d;
            out_data  <= out_data_d;
            out_valid <= out_valid_d;
            out_last  <= out_last_d;
            busy      <= busy_d;
            done      <= done_d;
            addr_err  <= addr_err_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        len_d       = len_q;
        rd_ptr_d    = rd_ptr_q;
        out_data_d  = out_data;
        out_valid_d = out_valid;
        out_last_d  = out_last;
        addr_err_d  = addr_err;
        buf_clear_c = 1'b0;
        buf_we_c    = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (conv_start) begin
                    state_d     = CAPTURE;
                    len_d       = new_len_c;
                    buf_clear_c = 1'b1;
                    addr_err_d  = 1'b0;
                end
            end
            CAPTURE: begin
                // A new start discards everything captured so far.
                if (conv_start) begin
                    len_d       = new_len_c;
                    buf_clear_c = 1'b1;
                    addr_err_d  = 1'b0;
                end else begin
                    if (conv_writeZ) begin
                        if (addr_ok_c) begin
                            buf_we_c = 1'b1;
                        end else begin
                            addr_err_d = 1'b1;
                        end
                    end
                    if (conv_done) begin
                        rd_ptr_d = '0;
                        state_d  = (len_q != '0) ? DRAIN : DONE;
                    end
                end
            end
            DRAIN: begin
                if (!out_valid) begin
                    out_data_d  = rd_data_c;
                    out_valid_d = 1'b1;
                    out_last_d  = (LEN_W'(rd_ptr_q) == len_q - LEN_ONE);
                end else if (out_ready) begin
                    if (out_last) begin
                        state_d     = DONE;
                        out_data_d  = '0;
                        out_valid_d = 1'b0;
                        out_last_d  = 1'b0;
                    end else begin
                        rd_ptr_d   = rd_idx_c;
                        out_data_d = rd_data_c;
                        out_last_d = (LEN_W'(rd_idx_c) == len_q - LEN_ONE);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d == CAPTURE) || (state_d == DRAIN);
        done_d = (state_d == DONE);
    end

endmodule

// File: tb/tb_convolution_z_readout.sv
// Directed self-checking bench for convolution_z_readout.
module tb_convolution_z_readout;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 6;

    logic          clk = 1'b0;
    logic          rstn = 1'b1;
    logic          conv_start = 1'b0;
    logic [4:0]    sizeX = '0;
    logic [4:0]    sizeY = '0;
    logic          conv_writeZ = 1'b0;
    logic [AW-1:0] conv_memZ_addr = '0;
    logic [DW-1:0] conv_dataZ = '0;
    logic          conv_done = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          out_last;
    logic          busy;
    logic          done;
    logic          addr_err;

    int errors = 0;
    int checks = 0;

    logic [DW-1:0] got_data[$];
    logic          got_last[$];
    int            stall_viol;
    bit            timed_out;

    convolution_z_readout dut (
        .clk            (clk),
        .rstn           (rstn),
        .conv_start     (conv_start),
        .sizeX          (sizeX),
        .sizeY          (sizeY),
        .conv_writeZ    (conv_writeZ),
        .conv_memZ_addr (conv_memZ_addr),
        .conv_dataZ     (conv_dataZ),
        .conv_done      (conv_done),
        .out_data       (out_data),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_last       (out_last),
        .busy           (busy),
        .done           (done),
        .addr_err       (addr_err)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input int sx, input int sy);
        conv_start = 1'b1;
        sizeX = 5'(sx);
        sizeY = 5'(sy);
        tick();
        conv_start = 1'b0;
    endtask

    task automatic write_z(input int a, input int d);
        conv_writeZ = 1'b1;
        conv_memZ_addr = AW'(a);
        conv_dataZ = DW'(d);
        tick();
        conv_writeZ = 1'b0;
    endtask

    task automatic pulse_done();
        conv_done = 1'b1;
        tick();
        conv_done = 1'b0;
    endtask

    // Collects accepted samples until done rises; bp selects ready pattern 1,0,0,...
    task automatic drain(input bit bp, input int max_cyc);
        logic          prev_stall;
        logic [DW-1:0] prev_data;
        logic          prev_last;
        got_data.delete();
        got_last.delete();
        stall_viol = 0;
        timed_out = 1'b1;
        prev_stall = 1'b0;
        prev_data = '0;
        prev_last = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            if (prev_stall && (out_valid !== 1'b1 || out_data !== prev_data || out_last !== prev_last))
                stall_viol++;
            out_ready = bp ? (c % 3 == 0) : 1'b1;
            if (out_valid && out_ready) begin
                got_data.push_back(out_data);
                got_last.push_back(out_last);
            end
            prev_stall = out_valid && !out_ready;
            prev_data = out_data;
            prev_last = out_last;
            tick();
            if (done === 1'b1) begin
                timed_out = 1'b0;
                break;
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rstn = 1'b1;
        tick();
        tick();
        rstn = 1'b0;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_out_data: got %h want 0", out_data); end
        checks++; if ({busy, done, addr_err, out_last} !== 4'b0) begin errors++; $display("FAIL reset_flags: got %b want 0000", {busy, done, addr_err, out_last}); end
    endtask

    task automatic test_basic();
        logic [DW-1:0] exp_d[5] = '{16'd1, 16'd4, 16'd10, 16'd12, 16'd9};
        start_run(3, 3);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL basic_busy_capture: got %b want 1", busy); end
        for (int i = 0; i < 5; i++) write_z(i, int'(exp_d[i]));
        pulse_done();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL basic_first_cycle_valid: got %b want 0", out_valid); end
        out_ready = 1'b1;
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (out_valid !== 1'b1 || out_data !== exp_d[i]) begin errors++; $display("FAIL basic_sample%0d: got v=%b d=%0d want v=1 d=%0d", i, out_valid, out_data, exp_d[i]); end
            checks++; if (out_last !== (i == 4)) begin errors++; $display("FAIL basic_last%0d: got %b want %b", i, out_last, (i == 4)); end
            tick();
        end
        out_ready = 1'b0;
        checks++; if ({done, busy, out_valid} !== 3'b100) begin errors++; $display("FAIL basic_done: got done/busy/valid=%b want 100", {done, busy, out_valid}); end
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width: got %b want 0", done); end
    endtask

    task automatic test_overwrite();
        logic [DW-1:0] exp_d[5] = '{16'd1, 16'd4, 16'd10, 16'd12, 16'd9};
        start_run(3, 3);
        write_z(0, 1); write_z(1, 4); write_z(2, 3); write_z(2, 7);
        write_z(2, 10); write_z(3, 12); write_z(4, 9);
        pulse_done();
        drain(1'b0, 40);
        checks++; if (timed_out || got_data.size() != 5) begin errors++; $display("FAIL overwrite_count: got %0d timeout=%b want 5", got_data.size(), timed_out); end
        for (int i = 0; i < got_data.size() && i < 5; i++) begin
            checks++; if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL overwrite_sample%0d: got %0d want %0d", i, got_data[i], exp_d[i]); end
        end
        tick();
    endtask

    task automatic test_back_pressure();
        logic [DW-1:0] exp_d[5] = '{16'hA001, 16'hA002, 16'hA003, 16'hA004, 16'hA005};
        start_run(2, 4);
        for (int i = 0; i < 5; i++) write_z(i, int'(exp_d[i]));
        pulse_done();
        drain(1'b1, 100);
        checks++; if (timed_out || got_data.size() != 5) begin errors++; $display("FAIL bp_count: got %0d timeout=%b want 5", got_data.size(), timed_out); end
        checks++; if (stall_viol != 0) begin errors++; $display("FAIL bp_hold: got %0d changes while stalled want 0", stall_viol); end
        for (int i = 0; i < got_data.size() && i < 5; i++) begin
            checks++; if (got_data[i] !== exp_d[i] || got_last[i] !== (i == 4)) begin errors++; $display("FAIL bp_sample%0d: got d=%h last=%b want d=%h last=%b", i, got_data[i], got_last[i], exp_d[i], (i == 4)); end
        end
        tick();
    endtask

    task automatic test_addr_err();
        logic [DW-1:0] exp_d[3] = '{16'h0, 16'h55, 16'h0};
        start_run(2, 2);
        write_z(5, 99);
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_set: got %b want 1", addr_err); end
        write_z(1, 16'h55);
        pulse_done();
        drain(1'b0, 40);
        checks++; if (timed_out || got_data.size() != 3) begin errors++; $display("FAIL err_count: got %0d timeout=%b want 3", got_data.size(), timed_out); end
        for (int i = 0; i < got_data.size() && i < 3; i++) begin
            checks++; if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL err_sample%0d: got %h want %h", i, got_data[i], exp_d[i]); end
        end
        checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %b want 1", addr_err); end
        tick();
        start_run(3, 3);
        checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL err_clear: got %b want 0", addr_err); end
    endtask

    task automatic test_zero_len();
        // Restart from the capture left open by the previous test.
        start_run(0, 3);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL zero_early_done: got %b want 0", done); end
        pulse_done();
        checks++; if ({done, busy, out_valid} !== 3'b100) begin errors++; $display("FAIL zero_done: got done/busy/valid=%b want 100", {done, busy, out_valid}); end
        tick();
        checks++; if ({done, out_valid} !== 2'b00) begin errors++; $display("FAIL zero_after: got done/valid=%b want 00", {done, out_valid}); end
        start_run(2, 1);
        write_z(0, 7);
        conv_writeZ = 1'b1;
        conv_memZ_addr = AW'(1);
        conv_dataZ = DW'(16'h21);
        pulse_done();
        conv_writeZ = 1'b0;
        drain(1'b0, 40);
        checks++; if (timed_out || got_data.size() != 2) begin errors++; $display("FAIL done_write_count: got %0d timeout=%b want 2", got_data.size(), timed_out); end
        else begin
            checks++; if (got_data[0] !== 16'd7 || got_data[1] !== 16'h21) begin errors++; $display("FAIL done_write_data: got %h %h want 0007 0021", got_data[0], got_data[1]); end
        end
        tick();
    endtask

    task automatic test_reset_mid_drain();
        logic [DW-1:0] exp_d[3] = '{16'd5, 16'd6, 16'd7};
        start_run(3, 3);
        for (int i = 0; i < 5; i++) write_z(i, 20 + i);
        pulse_done();
        out_ready = 1'b1;
        tick();
        tick();
        tick();
        out_ready = 1'b0;
        checks++; if (out_data !== 16'd22) begin errors++; $display("FAIL mid_third_sample: got %0d want 22", out_data); end
        rstn = 1'b1;
        tick();
        rstn = 1'b0;
        checks++; if ({out_valid, out_last, busy, done, addr_err} !== 5'b0 || out_data !== '0) begin errors++; $display("FAIL mid_reset_outputs: got flags=%b d=%h want 0", {out_valid, out_last, busy, done, addr_err}, out_data); end
        tick();
        checks++; if ({done, busy} !== 2'b00) begin errors++; $display("FAIL mid_no_done: got done/busy=%b want 00", {done, busy}); end
        start_run(2, 2);
        for (int i = 0; i < 3; i++) write_z(i, int'(exp_d[i]));
        pulse_done();
        drain(1'b0, 40);
        checks++; if (timed_out || got_data.size() != 3) begin errors++; $display("FAIL fresh_count: got %0d timeout=%b want 3", got_data.size(), timed_out); end
        for (int i = 0; i < got_data.size() && i < 3; i++) begin
            checks++; if (got_data[i] !== exp_d[i]) begin errors++; $display("FAIL fresh_sample%0d: got %0d want %0d", i, got_data[i], exp_d[i]); end
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overwrite();
        test_back_pressure();
        test_addr_err();
        test_zero_len();
        test_reset_mid_drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
